pc_redirect_ctrl: RTL



---
 rtl/pc_redirect_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/pc_redirect_ctrl.sv
// PC redirect sequencer: captures one jump/branch target, holds it until IF accepts it.
// Optional redirect performance counters are enabled with `define REDIRECT_PERF_EN.
module pc_redirect_ctrl #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  input  logic             ex_jump,
  input  logic             ex_jump_src,
  input  logic [PC_W-1:0]  jump_pc,
  input  logic             ex_branch_taken,
  input  logic [PC_W-1:0]  branch_pc,
  input  logic             if_stall,
  output logic             redirect_valid,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             redirect_busy,
  output logic             conflict,
  output logic [CNT_W-1:0] redirect_count,
  output logic [CNT_W-1:0] jr_count
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_active;
  logic [PC_W-1:0] r_pc;
  logic            r_conflict;
  logic            w_req;
  logic            w_accept;
  logic [PC_W-1:0] w_target;

  assign w_req    = ex_valid & (ex_jump | ex_branch_taken);
  assign w_target = ex_branch_taken ? branch_pc : jump_pc;
  assign w_accept = r_active & ~if_stall;

  // Redirect FSM: capture in IDLE, hold target until an unstalled IF cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_active   <= 1'b0;
      r_pc       <= '0;
      r_conflict <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_state  <= REDIRECT;
            r_active <= 1'b1;
            r_pc     <= w_target;
            if (ex_jump & ex_branch_taken) begin
              r_conflict <= 1'b1;
            end else begin
              r_conflict <= r_conflict;
            end
          end else begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end
        end
        REDIRECT, HOLD: begin
          // Requests seen here are wrong-path and are dropped, not queued
          if (!if_stall) begin
            r_state  <= IDLE;
            r_active <= 1'b0;
          end else begin
            r_state  <= HOLD;
            r_active <= 1'b1;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign redirect_valid = r_active;
  assign flush_ifid     = r_active;
  assign flush_idex     = r_active;
  assign redirect_busy  = r_active;
  assign redirect_pc    = r_pc;
  assign conflict       = r_conflict;

`ifdef REDIRECT_PERF_EN
  logic             r_src_jr;
  logic [CNT_W-1:0] r_redirect_count;
  logic [CNT_W-1:0] r_jr_count;

  // Accept counters; source type is latched alongside the target
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_jr         <= 1'b0;
      r_redirect_count <= '0;
      r_jr_count       <= '0;
    end else begin
      if ((r_state == IDLE) && w_req) begin
        r_src_jr <= ex_jump & ~ex_branch_taken & ex_jump_src;
      end else begin
        r_src_jr <= r_src_jr;
      end
      if (w_accept) begin
        r_redirect_count <= r_redirect_count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (r_src_jr) begin
          r_jr_count <= r_jr_count + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          r_jr_count <= r_jr_count;
        end
      end else begin
        r_redirect_count <= r_redirect_count;
        r_jr_count       <= r_jr_count;
      end
    end
  end

  assign redirect_count = r_redirect_count;
  assign jr_count       = r_jr_count;
`else
  logic w_unused_perf;
  assign w_unused_perf  = &{1'b0, ex_jump_src, w_accept};
  assign redirect_count = '0;
  assign jr_count       = '0;
`endif

endmodule
